// File: rtl/afifo_test_pkg.sv
// afifo_test_pkg: types and constants shared by the async FIFO test harness
// (read-side checker, write-side generator and testbench).
// FSM state encoding, throttle LFSR seed/taps, and counter/sum widths.
package afifo_test_pkg;

  // Accumulator widths, shared with the write side so both ends agree.
  localparam int SUM_W = 64;
  localparam int CNT_W = 32;

  // Read checker FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16_throttle.sv
// lfsr16_throttle: free-running 16-bit Fibonacci LFSR producing a dequeue
// permission bit with roughly 75% duty cycle. Used only when THROTTLE_EN
// is defined in the read checker build.
module lfsr16_throttle
  import afifo_test_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  output logic allow
);

  logic [15:0] r_lfsr;

  // LFSR advances every cycle; reseeded on reset so runs are repeatable.
  always_ff @(posedge CLK) begin
    if (RST) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= lfsr16_next(r_lfsr);
  end

  // Blocks a dequeue on one of four low-bit patterns (about 25% of cycles).
  assign allow = (r_lfsr[1:0] != 2'b00);

endmodule

// File: rtl/fifo_read_checker.sv
// fifo_read_checker: read-side endpoint of the async FIFO test harness.
// Drains NUM_WORDS words from a first-word-fall-through FIFO, accumulating a
// count and 64-bit sum, and checks each word against an incrementing
// sequence starting at START_VAL (wrapping modulo 2^DATA_W). The first
// mismatch is latched into err_index/err_data; error and done are sticky.
// Build option: define THROTTLE_EN to gate dequeues with an LFSR so the
// write side sees backpressure; otherwise every eligible cycle dequeues.
module fifo_read_checker
  import afifo_test_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 1000,
  parameter logic [63:0] START_VAL = 64'd0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] read_data,
  input  logic              empty,
  output logic              deq,
  output logic [CNT_W-1:0]  counter,
  output logic [SUM_W-1:0]  sum,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_index,
  output logic [DATA_W-1:0] err_data
);

  localparam logic [DATA_W-1:0] START_V  = START_VAL[DATA_W-1:0];
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_counter;
  logic [SUM_W-1:0]   r_sum;
  logic [DATA_W-1:0]  r_expected;
  logic               r_done;
  logic               r_error;
  logic [CNT_W-1:0]   r_err_index;
  logic [DATA_W-1:0]  r_err_data;

  logic               w_allow;
  logic               w_deq;
  logic               w_last;
  logic               w_mismatch;

`ifdef THROTTLE_EN
  lfsr16_throttle u_throttle (
    .CLK   (CLK),
    .RST   (RST),
    .allow (w_allow)
  );
`else
  assign w_allow = 1'b1;
`endif

  // Dequeue depends only on state, empty and throttle -- never on the data,
  // so the FIFO sees no combinational path from its own read port.
  assign w_deq      = !RST && (r_state == ST_READ) && !empty && w_allow;
  assign w_last     = (r_counter == LAST_IDX);
  assign w_mismatch = (read_data != r_expected);

  // Control FSM: one idle cycle after reset, read until the last word, then park.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_READ;
        ST_READ: if (w_deq && w_last) r_state <= ST_DONE;
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky done flag, raised on the same edge as the final counter increment.
  always_ff @(posedge CLK) begin
    if (RST)                  r_done <= 1'b0;
    else if (w_deq && w_last) r_done <= 1'b1;
  end

  // Word count and zero-extended running sum (sum wraps modulo 2^64).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_counter <= '0;
      r_sum     <= '0;
    end else if (w_deq) begin
      r_counter <= r_counter + 1'b1;
      r_sum     <= r_sum + SUM_W'(read_data);
    end
  end

  // Expected-value tracker; advances on every consume and never resyncs to
  // the data, so one bad word does not hide later ones.
  always_ff @(posedge CLK) begin
    if (RST)        r_expected <= START_V;
    else if (w_deq) r_expected <= r_expected + 1'b1;
  end

  // First-mismatch capture; later mismatches leave the captured info intact.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_err_data  <= '0;
    end else if (w_deq && w_mismatch && !r_error) begin
      r_error     <= 1'b1;
      r_err_index <= r_counter;
      r_err_data  <= read_data;
    end
  end

  assign deq       = w_deq;
  assign counter   = r_counter;
  assign sum       = r_sum;
  assign done      = r_done;
  assign error     = r_error;
  assign err_index = r_err_index;
  assign err_data  = r_err_data;

endmodule

// File: tb/tb_fifo_read_checker.sv
// tb_fifo_read_checker: table-driven bench for fifo_read_checker.
// Several DUT instances with different parameter sets share clock and reset;
// a small FIFO model feeds the selected instance, a reference model predicts
// deq and the accumulated state, and a scoreboard queue holds the expected
// results of each consume until the DUT shows them after the clock edge.
`timescale 1ns/1ps
module tb_fifo_read_checker;
  import afifo_test_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Per-instance FIFO head / empty inputs.
  logic [31:0] rd0 = '0, rd1 = '0, rd2 = '0, rd4 = '0;
  logic [7:0]  rd3 = '0;
  logic        e0 = 1'b1, e1 = 1'b1, e2 = 1'b1, e3 = 1'b1, e4 = 1'b1;

  // Per-instance outputs.
  logic        dq0, dq1, dq2, dq3, dq4;
  logic [31:0] c0, c1, c2, c3, c4;
  logic [63:0] s0, s1, s2, s3, s4;
  logic        dn0, dn1, dn2, dn3, dn4;
  logic        er0, er1, er2, er3, er4;
  logic [31:0] ei0, ei1, ei2, ei3, ei4;
  logic [31:0] ed0, ed1, ed2, ed4;
  logic [7:0]  ed3;

  // 0: basic / reset-mid-run, 1: empty stall, 2: mismatch, 3: 8-bit wrap, 4: long run
  fifo_read_checker #(.DATA_W(32), .NUM_WORDS(4), .START_VAL(64'd0)) u_dut0 (
    .CLK(clk), .RST(rst), .read_data(rd0), .empty(e0), .deq(dq0), .counter(c0), .sum(s0),
    .done(dn0), .error(er0), .err_index(ei0), .err_data(ed0));
  fifo_read_checker #(.DATA_W(32), .NUM_WORDS(3), .START_VAL(64'd5)) u_dut1 (
    .CLK(clk), .RST(rst), .read_data(rd1), .empty(e1), .deq(dq1), .counter(c1), .sum(s1),
    .done(dn1), .error(er1), .err_index(ei1), .err_data(ed1));
  fifo_read_checker #(.DATA_W(32), .NUM_WORDS(5), .START_VAL(64'd0)) u_dut2 (
    .CLK(clk), .RST(rst), .read_data(rd2), .empty(e2), .deq(dq2), .counter(c2), .sum(s2),
    .done(dn2), .error(er2), .err_index(ei2), .err_data(ed2));
  fifo_read_checker #(.DATA_W(8), .NUM_WORDS(3), .START_VAL(64'hFE)) u_dut3 (
    .CLK(clk), .RST(rst), .read_data(rd3), .empty(e3), .deq(dq3), .counter(c3), .sum(s3),
    .done(dn3), .error(er3), .err_index(ei3), .err_data(ed3));
  fifo_read_checker #(.DATA_W(32), .NUM_WORDS(1000), .START_VAL(64'd0)) u_dut4 (
    .CLK(clk), .RST(rst), .read_data(rd4), .empty(e4), .deq(dq4), .counter(c4), .sum(s4),
    .done(dn4), .error(er4), .err_index(ei4), .err_data(ed4));

  int nchecks = 0;
  int nerrors = 0;

  // Sampled outputs of the selected instance.
  logic        o_deq, o_done, o_err;
  logic [31:0] o_cnt, o_eidx, o_edat;
  logic [63:0] o_sum;

  typedef struct {
    string       name;
    int          inst;
    int          nwords;
    logic [31:0] start;
    logic [31:0] mask;
    int          len;
    logic [31:0] words [6];
    int          stall_at;
    int          stall_len;
    int          rst_after;
    logic [31:0] x_cnt;
    logic [63:0] x_sum;
    logic        x_err;
    logic [31:0] x_eidx;
    logic [31:0] x_edat;
  } vec_t;

  typedef struct {
    logic [31:0] cnt;
    logic [63:0] sum;
    logic        err;
    logic [31:0] eidx;
    logic [31:0] edat;
    logic        done;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int k, input logic [31:0] d, input logic e);
    case (k)
      0: begin rd0 = d;      e0 = e; end
      1: begin rd1 = d;      e1 = e; end
      2: begin rd2 = d;      e2 = e; end
      3: begin rd3 = d[7:0]; e3 = e; end
      default: begin rd4 = d; e4 = e; end
    endcase
  endtask

  task automatic all_empty();
    e0 = 1'b1; e1 = 1'b1; e2 = 1'b1; e3 = 1'b1; e4 = 1'b1;
  endtask

  task automatic sample(input int k);
    case (k)
      0: begin o_deq = dq0; o_cnt = c0; o_sum = s0; o_done = dn0; o_err = er0; o_eidx = ei0; o_edat = ed0; end
      1: begin o_deq = dq1; o_cnt = c1; o_sum = s1; o_done = dn1; o_err = er1; o_eidx = ei1; o_edat = ed1; end
      2: begin o_deq = dq2; o_cnt = c2; o_sum = s2; o_done = dn2; o_err = er2; o_eidx = ei2; o_edat = ed2; end
      3: begin o_deq = dq3; o_cnt = c3; o_sum = s3; o_done = dn3; o_err = er3; o_eidx = ei3; o_edat = {24'h0, ed3}; end
      default: begin o_deq = dq4; o_cnt = c4; o_sum = s4; o_done = dn4; o_err = er4; o_eidx = ei4; o_edat = ed4; end
    endcase
  endtask

  // Two-edge reset with data present: deq must stay low and outputs clear.
  task automatic do_reset(input string nm, input int k, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b1;
    all_empty();
    drive(k, d, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1 sample(k);
    chk({nm, ".rst_deq"}, 64'(o_deq), 64'd0);
    @(posedge clk);
    #1 sample(k);
    chk({nm, ".rst_cnt"},  64'(o_cnt), 64'd0);
    chk({nm, ".rst_sum"},  o_sum, 64'd0);
    chk({nm, ".rst_done"}, 64'(o_done), 64'd0);
    chk({nm, ".rst_err"},  64'(o_err), 64'd0);
  endtask

  task automatic run_case(input vec_t v);
    int          mst, idx, stall_cnt, tail, cyc;
    logic [31:0] mcnt, mexp, meidx, medat, w;
    logic [63:0] msum;
    logic        merr, mdone, present, mdeq, allow_m, rstv, did_rst, stalling;
    exp_t        e;
    do_reset(v.name, v.inst, v.words[0]);
    mst = 0; idx = 0; stall_cnt = 0; tail = 0; cyc = 0;
    mcnt = '0; msum = '0; mexp = v.start; merr = 1'b0; meidx = '0; medat = '0; mdone = 1'b0;
    did_rst = 1'b0;
    sb.delete();
    while (cyc < 200 && tail < 3) begin
      cyc++;
      @(negedge clk);
      rstv = 1'b0;
      if (!did_rst && v.rst_after >= 0 && mcnt == 32'(v.rst_after)) begin
        rstv = 1'b1;
        did_rst = 1'b1;
      end
      rst = rstv;
      stalling = (idx == v.stall_at) && (stall_cnt < v.stall_len);
      present  = (idx < v.len) && !stalling;
      if (stalling) stall_cnt++;
      w = (idx < v.len) ? v.words[idx] : 32'h0;
      drive(v.inst, w, !present);
      #1 sample(v.inst);
`ifdef THROTTLE_EN
      allow_m = o_deq;
`else
      allow_m = 1'b1;
`endif
      mdeq = !rstv && (mst == 1) && present && allow_m;
      chk({v.name, ".deq"}, 64'(o_deq), 64'(mdeq));
      if (rstv) begin
        mst = 0; idx = 0; stall_cnt = 0;
        mcnt = '0; msum = '0; mexp = v.start; merr = 1'b0; meidx = '0; medat = '0; mdone = 1'b0;
      end else begin
        if (mdeq) begin
          if (w != mexp && !merr) begin
            merr = 1'b1; meidx = mcnt; medat = w;
          end
          msum = msum + {32'h0, w};
          mexp = (mexp + 1) & v.mask;
          mcnt = mcnt + 1;
          if (mcnt == 32'(v.nwords)) mdone = 1'b1;
          e.cnt = mcnt; e.sum = msum; e.err = merr; e.eidx = meidx; e.edat = medat; e.done = mdone;
          sb.push_back(e);
          idx++;
        end
        if (mst == 0)                                    mst = 1;
        else if (mst == 1 && mdeq && mcnt == 32'(v.nwords)) mst = 2;
      end
      @(posedge clk);
      #1 sample(v.inst);
      if (rstv) begin
        chk({v.name, ".mid_rst_cnt"},  64'(o_cnt), 64'd0);
        chk({v.name, ".mid_rst_sum"},  o_sum, 64'd0);
        chk({v.name, ".mid_rst_done"}, 64'(o_done), 64'd0);
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({v.name, ".cnt"},  64'(o_cnt), 64'(e.cnt));
        chk({v.name, ".sum"},  o_sum, e.sum);
        chk({v.name, ".err"},  64'(o_err), 64'(e.err));
        chk({v.name, ".eidx"}, 64'(o_eidx), 64'(e.eidx));
        chk({v.name, ".edat"}, 64'(o_edat), 64'(e.edat));
        chk({v.name, ".done"}, 64'(o_done), 64'(e.done));
      end
      if (mdone) tail++;
    end
    chk({v.name, ".finished_in_budget"}, 64'(tail >= 3), 64'd1);
    chk({v.name, ".final_cnt"},  64'(o_cnt), 64'(v.x_cnt));
    chk({v.name, ".final_sum"},  o_sum, v.x_sum);
    chk({v.name, ".final_done"}, 64'(o_done), 64'd1);
    chk({v.name, ".final_err"},  64'(o_err), 64'(v.x_err));
    chk({v.name, ".final_eidx"}, 64'(o_eidx), 64'(v.x_eidx));
    chk({v.name, ".final_edat"}, 64'(o_edat), 64'(v.x_edat));
  endtask

  // Long continuous run on the 1000-word instance: totals and duty cycle.
  task automatic run_long();
    int idx, read_cycles, deq_cycles, cyc;
    logic first;
    do_reset("long", 4, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idx = 0; read_cycles = 0; deq_cycles = 0; cyc = 0; first = 1'b1;
    while (cyc < 4000) begin
      drive(4, 32'(idx), 1'b0);
      #1 sample(4);
      if (o_done) break;
      if (!first) read_cycles++;
      first = 1'b0;
      if (o_deq) deq_cycles++;
      @(posedge clk);
      if (o_deq) idx++;
      @(negedge clk);
      cyc++;
    end
    chk("long.finished_in_budget", 64'(o_done), 64'd1);
    chk("long.cnt",  64'(o_cnt), 64'd1000);
    chk("long.sum",  o_sum, 64'd499500);
    chk("long.err",  64'(o_err), 64'd0);
    chk("long.deq_cycles", 64'(deq_cycles), 64'd1000);
`ifdef THROTTLE_EN
    chk("long.duty_in_70_80", 64'((deq_cycles * 100 >= read_cycles * 70) && (deq_cycles * 100 <= read_cycles * 80)), 64'd1);
`else
    chk("long.read_cycles", 64'(read_cycles), 64'd1000);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(4, 32'(idx), 1'b0);
      #1 sample(4);
      chk("long.deq_after_done", 64'(o_deq), 64'd0);
      chk("long.cnt_after_done", 64'(o_cnt), 64'd1000);
    end
  endtask

  initial begin
    //          name        inst nw start   mask        len words                         stall  rst  cnt sum      err eidx edat
    vecs[0] = '{"basic",     0, 4, 32'h0,  32'hFFFFFFFF, 5, '{0, 1, 2, 3, 4, 0},         -1, 0, -1, 4, 64'd6,    0, 0, 0};
    vecs[1] = '{"stall",     1, 3, 32'h5,  32'hFFFFFFFF, 3, '{5, 6, 7, 0, 0, 0},          2, 3, -1, 3, 64'd18,   0, 0, 0};
    vecs[2] = '{"mismatch",  2, 5, 32'h0,  32'hFFFFFFFF, 5, '{0, 1, 9, 3, 7, 0},         -1, 0, -1, 5, 64'd20,   1, 2, 9};
    vecs[3] = '{"wrap",      3, 3, 32'hFE, 32'h000000FF, 3, '{32'hFE, 32'hFF, 0, 0, 0, 0}, -1, 0, -1, 3, 64'h1FD, 0, 0, 0};
    vecs[4] = '{"rst_mid",   0, 4, 32'h0,  32'hFFFFFFFF, 4, '{0, 1, 2, 3, 0, 0},         -1, 0,  2, 4, 64'd6,    0, 0, 0};
    for (int i = 0; i < 5; i++) run_case(vecs[i]);
    run_long();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
